// File: rtl/multicycle_serial_tx.sv
// Framed serializer: start bit, DATA_WIDTH data bits LSB first, stop bit,
// each held for DIV clocks. All outputs come straight from flops.
module multicycle_serial_tx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out,
    output logic                  busy
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e                state_q;
    logic [DIV_W-1:0]      div_cnt_q;
    logic [IDX_W-1:0]      bit_idx_q;
    logic [DATA_WIDTH-1:0] shift_reg_q;
    logic [DATA_WIDTH-1:0] shift_reg_d;
    logic                  out_q;
    logic                  busy_q;
    logic                  in_ready_q;
    logic                  bit_end;

    always_comb begin
        shift_reg_d = shift_reg_q >> 1;
        bit_end     = (div_cnt_q == DIV_W'(DIV - 1));
    end

    // out_q is loaded with the value the line must carry in the next state,
    // so it tracks shift_reg_q[0] during DATA without a combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_reg_q <= '0;
            out_q       <= 1'b1;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg_q <= in_data;
                        state_q     <= START;
                        div_cnt_q   <= '0;
                        out_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        in_ready_q  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        div_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                        out_q     <= shift_reg_q[0];
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        div_cnt_q <= '0;
                        if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                            state_q <= STOP;
                            out_q   <= 1'b1;
                        end else begin
                            shift_reg_q <= shift_reg_d;
                            bit_idx_q   <= bit_idx_q + 1'b1;
                            out_q       <= shift_reg_d[0];
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        div_cnt_q  <= '0;
                        state_q    <= IDLE;
                        out_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    div_cnt_q  <= '0;
                    out_q      <= 1'b1;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign in_ready = in_ready_q;

endmodule

// File: tb/tb_multicycle_serial_tx.sv
// Directed bench: DIV=4/W=8 instance for frame tables and corner cases,
// DIV=1/W=4 instance for the single-cycle-bit case.
module tb_multicycle_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data;
    logic       a_valid, a_ready, a_out, a_busy;
    logic [3:0] b_data;
    logic       b_valid, b_ready, b_out, b_busy;

    int n_vec = 0;
    int n_mis = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    multicycle_serial_tx #(.DATA_WIDTH(8), .DIV(4)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .out(a_out), .busy(a_busy)
    );

    multicycle_serial_tx #(.DATA_WIDTH(4), .DIV(1)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .out(b_out), .busy(b_busy)
    );

    always @(posedge clk)
        if (!rst && a_valid && a_ready) hs_cnt <= hs_cnt + 1;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit i = line value during bit period i
        string      name;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_a(input string nm);
        chk({nm, " idle out"}, 32'(a_out), 1);
        chk({nm, " idle busy"}, 32'(a_busy), 0);
        chk({nm, " idle ready"}, 32'(a_ready), 1);
    endtask

    task automatic send_a(input logic [7:0] d, input string nm);
        chk({nm, " ready before send"}, 32'(a_ready), 1);
        a_valid = 1'b1;
        a_data  = d;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic frame_a(input logic [9:0] frame, input string nm, input int n_checks,
                           input int inject_at, input logic [7:0] inject_data,
                           input bit drop_at_end);
        for (int c = 0; c < n_checks; c++) begin
            chk($sformatf("%s out c%0d", nm, c), 32'(a_out), 32'(frame[c/4]));
            chk($sformatf("%s busy c%0d", nm, c), 32'(a_busy), 1);
            chk($sformatf("%s ready c%0d", nm, c), 32'(a_ready), 0);
            if (c == inject_at) begin
                a_valid = 1'b1;
                a_data  = inject_data;
            end
            if (c == 39 && drop_at_end) a_valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] b_frame;
        vecs[0] = '{8'hA5, 10'h34A, "A5"};
        vecs[1] = '{8'h55, 10'h2AA, "55"};
        vecs[2] = '{8'h81, 10'h302, "81"};
        vecs[3] = '{8'h3C, 10'h278, "3C"};
        vecs[4] = '{8'hF0, 10'h3E0, "F0"};
        vecs[5] = '{8'h00, 10'h200, "00"};
        vecs[6] = '{8'hFF, 10'h3FE, "FF"};

        rst = 1'b1; a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0;
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            idle_a("reset");
            chk("reset b out", 32'(b_out), 1);
            chk("reset b busy", 32'(b_busy), 0);
            chk("reset b ready", 32'(b_ready), 1);
            tick();
        end

        foreach (vecs[i]) begin
            send_a(vecs[i].data, vecs[i].name);
            frame_a(vecs[i].frame, vecs[i].name, 40, -1, 8'h00, 1'b0);
            idle_a({vecs[i].name, " end"});
            tick();
        end

        // back-to-back with in_valid held high
        hs_cnt = 0;
        a_valid = 1'b1; a_data = 8'h00;
        tick();
        a_data = 8'hFF;
        frame_a(10'h200, "b2b0", 40, -1, 8'h00, 1'b0);
        idle_a("b2b gap");
        tick();
        frame_a(10'h3FE, "b2b1", 40, -1, 8'h00, 1'b1);
        idle_a("b2b end");
        tick();
        idle_a("b2b after");
        chk("b2b handshakes", 32'(hs_cnt), 2);

        // in_valid during DATA is ignored, then accepted at the first IDLE edge
        hs_cnt = 0;
        send_a(8'h81, "ign");
        frame_a(10'h302, "ign81", 40, 16, 8'h3C, 1'b0);
        idle_a("ign gap");
        tick();
        frame_a(10'h278, "ign3C", 40, -1, 8'h00, 1'b1);
        idle_a("ign end");
        tick();
        chk("ign handshakes", 32'(hs_cnt), 2);

        // reset during bit_idx=3, with in_valid asserted on the same edge
        hs_cnt = 0;
        send_a(8'hF0, "abort");
        frame_a(10'h3E0, "abortF0", 17, -1, 8'h00, 1'b0);
        rst = 1'b1; a_valid = 1'b1; a_data = 8'hAA;
        tick();
        rst = 1'b0; a_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idle_a("post-abort");
            tick();
        end
        chk("abort handshakes", 32'(hs_cnt), 1);
        send_a(8'h55, "after");
        frame_a(10'h2AA, "after55", 40, -1, 8'h00, 1'b0);
        idle_a("after end");
        tick();

        // DIV=1, DATA_WIDTH=4: 0x9 -> 0,1,0,0,1,1
        b_frame = 6'b110010;
        chk("div1 ready before", 32'(b_ready), 1);
        b_valid = 1'b1; b_data = 4'h9;
        tick();
        b_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("div1 out c%0d", c), 32'(b_out), 32'(b_frame[c]));
            chk($sformatf("div1 busy c%0d", c), 32'(b_busy), 1);
            chk($sformatf("div1 ready c%0d", c), 32'(b_ready), 0);
            tick();
        end
        chk("div1 end ready", 32'(b_ready), 1);
        chk("div1 end busy", 32'(b_busy), 0);
        chk("div1 end out", 32'(b_out), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/multicycle_serial_tx.md
Name: multicycle_serial_tx

Overview:
Single-clock serializer benchmark for timing-constraint tests.
- Accepts a parallel word on a valid/ready handshake.
- Transmits it as a framed serial stream: start bit, data LSB first, stop bit. Each bit is held for DIV clock cycles.
- This is the transmitting end for capture-register benchmarks. Its shift-register-to-out paths change only every DIV cycles, so they exercise set_multicycle_path. SDC example: create_clock -period 5 -name clk clk; set_multicycle_path -setup 4 -from [get_cells shift_reg*] -to [get_ports out].

Parameters:
DATA_WIDTH, 8, payload bits per frame (>=1)
DIV, 4, clock cycles per serial bit (>=1); DIV=1 is legal

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous active-high reset
in_data  input  DATA_WIDTH  parallel word, sampled only on handshake
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word
out  output  1  serial line, idle high
busy  output  1  frame in progress

Behaviour:
- Reset: rst high at a posedge forces state=IDLE, out=1, busy=0, in_ready=1, all counters=0, shift register=0. Reset is synchronous only; rst has no effect between edges.
- Reset mid-frame aborts the frame:
  - out=1 from the reset edge onward.
  - No partial stop bit is emitted.
  - in_ready=1 from the reset edge.
- States:
  - IDLE: out=1, in_ready=1, busy=0.
  - START: out=0.
  - DATA: out = shift_reg[0].
  - STOP: out=1.
  - In START, DATA and STOP: in_ready=0, busy=1.
- Handshake: a transfer occurs at a posedge when in_valid && in_ready.
  - in_data is latched into shift_reg.
  - State goes to START and div_cnt=0.
  - in_valid while in_ready=0 is ignored; the word is not queued and no error is flagged.
- Bit timing: div_cnt counts 0..DIV-1 in every non-IDLE state. A bit period ends when div_cnt==DIV-1 at a posedge; div_cnt then wraps to 0.
  - START -> DATA: bit_idx=0.
  - DATA, bit_idx<DATA_WIDTH-1: shift_reg shifts right by 1 (MSB filled with 0), bit_idx increments.
  - DATA, bit_idx==DATA_WIDTH-1: -> STOP.
  - STOP -> IDLE.
- Outputs are registered. out, in_ready and busy are driven from state and shift_reg flops; no combinational path from inputs to outputs.
- Latency:
  - out goes low in the cycle immediately after the accepting edge.
  - Frame length is (DATA_WIDTH+2)*DIV cycles of non-idle line time.
  - in_ready is high again in the first cycle after the last STOP cycle.
- Back-to-back: the next word is accepted at the first IDLE edge. The minimum gap between frames is therefore 1 idle cycle (out=1), in addition to the stop bit.
- Widths: div_cnt is clog2(DIV) bits, minimum 1. bit_idx is clog2(DATA_WIDTH) bits, minimum 1. No wrap beyond DIV-1 or DATA_WIDTH-1 is permitted.
- Simultaneous rst and in_valid: reset wins and no transfer occurs.
- DIV=1: each bit lasts exactly one cycle and div_cnt stays at 0.
- DATA_WIDTH=1: the DATA state lasts one bit period.

Test Plan:
- Reset with in_valid=0, then hold idle for 10 cycles -> out=1, in_ready=1, busy=0 on every cycle.
- DIV=4, DATA_WIDTH=8: send 0xA5 -> out sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. busy is high for exactly 40 cycles. in_ready returns to 1 in cycle 41 after acceptance.
- Back-to-back: in_valid held high with 0x00 then 0xFF, DIV=4 -> first frame 0, eight 0s, 1; one idle cycle out=1; second frame 0, eight 1s, 1. Exactly two handshakes occur.
- Apply in_valid=1 with in_data=0x3C during DATA of a 0x81 frame -> 0x3C is ignored and 0x81 is transmitted intact. After the frame, if in_valid is still high, 0x3C is accepted at the first IDLE edge.
- Assert rst for 1 cycle at bit_idx=3 of a 0xF0 frame -> out=1 and in_ready=1 from the reset edge. No stop bit or further data follows. A new word 0x55 sent afterwards is a clean 40-cycle frame.
- DIV=1, DATA_WIDTH=4: send 0x9 -> out for 6 consecutive cycles is 0,1,0,0,1,1. busy is high for 6 cycles.
